cmos_stream_delay: RTL and testbench
====================================

# cmos_stream_delay

Parametrised, runtime-adjustable delay line for the CMOS/audio capture path. It delays a data bus and its sideband control bits (href, vsync, …) by a matching number of sample-enable cycles, so control and payload stay aligned with downstream FIFO and command logic. The delay value is selectable from 1 to MAX_DELAY and is only changed at frame boundaries (vsync rising edge), so no line is ever torn. Outputs are suppressed until the pipeline holds valid history.

## Interface
- DATA_WIDTH, 8, payload width
- CTRL_WIDTH, 2, sideband bit count (bit 0 href, bit 1 vsync by convention)
- VSYNC_BIT, 1, index in ctrl_in used for frame-boundary detection; must be < CTRL_WIDTH
- MAX_DELAY, 16, deepest delay in ce cycles; ≥ 1
- DEFAULT_DELAY, 3, delay in force after reset; 1..MAX_DELAY
- SEL_W, $clog2(MAX_DELAY+1), width of delay fields (derived, not overridden)

- sck  in  1  sample clock
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  sample enable; all state advances only when high
- delay_sel  in  SEL_W  requested delay, captured at frame boundary
- ctrl_in  in  CTRL_WIDTH  sideband input
- data_in  in  DATA_WIDTH  payload input
- ctrl_out  out  CTRL_WIDTH  delayed sideband
- data_out  out  DATA_WIDTH  delayed payload
- delay_valid  out  1  high once history depth ≥ active delay
- active_delay  out  SEL_W  delay currently applied

## Operation
- Storage: MAX_DELAY-stage shift chain, each stage {ctrl, data}. On sck rising edge with ce=1: stage[0] ← {ctrl_in, data_in}; stage[k] ← stage[k-1]. ce=0: all stages hold.
- Output tap: {ctrl_out, data_out} = stage[active_delay-1] when delay_valid=1, else all zeros. Output is a mux of registers; no combinational path from inputs.
- Clamping of delay_sel at capture: 0 → 1; > MAX_DELAY → MAX_DELAY; else unchanged.
- Frame-boundary detect: vsync_prev register updated with ctrl_in[VSYNC_BIT] on each ce cycle. Boundary = ce & ctrl_in[VSYNC_BIT] & ~vsync_prev.
- On boundary: active_delay ← clamp(delay_sel). Stage shift in the same cycle proceeds normally.
- History counter fill_cnt: increments on each ce cycle, saturates at MAX_DELAY; not cleared by delay changes.
- delay_valid = (fill_cnt ≥ active_delay), registered-state combinational compare.
- Delay increase: taps older history already present (valid once fill_cnt saturated); samples around the boundary may repeat. Delay decrease: samples skipped. Both acceptable only because change happens at vsync edge.

## Timing
- Reset (async assert, sync-free release): stages = 0, vsync_prev = 0, fill_cnt = 0, active_delay = DEFAULT_DELAY; ctrl_out = 0, data_out = 0, delay_valid = 0.
- Latency: sample captured on ce edge n appears at outputs after ce edge n+D-1 (D = active_delay), i.e. D ce-qualified edges total; with ce tied high and D=3, identical to a 3-register pipeline.
- Fill: delay_valid rises after the D-th ce edge following reset.
- Boundary capture: new active_delay visible after the same edge that sampled the vsync rise; output tap switches on that edge.
- vsync high at first ce after reset counts as a boundary (vsync_prev=0).
- ce low on a cycle where vsync rises: not a boundary; evaluated on next ce cycle.
- delay_sel changes away from boundaries: ignored.
- Reset mid-frame: all state cleared immediately; outputs 0 until refilled with DEFAULT_DELAY.

## Test plan
- Reset then ce=1, data_in = incrementing 0x00,0x01,…: data_out = 0 and delay_valid = 0 for first 2 edges; after edge 3 data_out = 0x00, then tracks input lagging 3.
- ce toggled 1-0-1-0 with counting data, D=3: data_out advances only on ce edges; 3 ce edges latency, held values during ce=0.
- delay_sel=8 mid-line (no vsync edge): active_delay stays 3; then vsync 0→1: active_delay = 8 after that edge, data_out = sample from 8 ce edges earlier.
- delay_sel=0 at boundary → active_delay=1; delay_sel=31 (MAX_DELAY=16) → active_delay=16, delay_valid stays low until fill_cnt ≥ 16.
- href/vsync pulse pattern with random data, D=5: ctrl_out and data_out match input exactly 5 ce edges later, bit-aligned.
- Assert rst for one cycle mid-stream: outputs drop to 0 asynchronously, active_delay = 3, delay_valid low for 2 ce edges after release.

Source files
------------

// File: rtl/cmos_stream_delay_if.sv
// Stream-side signal bundle for cmos_stream_delay: sample enable, delay request,
// sideband/payload in, and the delayed sideband/payload with status out.
interface cmos_stream_delay_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CTRL_WIDTH = 2,
    parameter int unsigned MAX_DELAY  = 16
);
    localparam int unsigned SEL_W = $clog2(MAX_DELAY + 1);

    logic                  ce;
    logic [SEL_W-1:0]      delay_sel;
    logic [CTRL_WIDTH-1:0] ctrl_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [CTRL_WIDTH-1:0] ctrl_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  delay_valid;
    logic [SEL_W-1:0]      active_delay;

    modport master (
        output ce, delay_sel, ctrl_in, data_in,
        input  ctrl_out, data_out, delay_valid, active_delay
    );

    modport slave (
        input  ce, delay_sel, ctrl_in, data_in,
        output ctrl_out, data_out, delay_valid, active_delay
    );
endinterface

// File: rtl/cmos_stream_delay.sv
// Runtime-adjustable delay line keeping sideband and payload aligned; the delay
// only changes on a vsync rising edge so lines are never torn.
module cmos_stream_delay #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CTRL_WIDTH    = 2,
    parameter int unsigned VSYNC_BIT     = 1,
    parameter int unsigned MAX_DELAY     = 16,
    parameter int unsigned DEFAULT_DELAY = 3,
    localparam int unsigned SEL_W        = $clog2(MAX_DELAY + 1)
) (
    input  logic                 sck,
    input  logic                 rst,
    cmos_stream_delay_if.slave   bus
);
    localparam int unsigned STAGE_W = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [SEL_W-1:0] ONE_SEL = SEL_W'(1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_DELAY);

    typedef logic [STAGE_W-1:0] stage_t;

    stage_t           stage_q [MAX_DELAY];
    stage_t           stage_d [MAX_DELAY];
    logic             vsync_prev_q, vsync_prev_d;
    logic [SEL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [SEL_W-1:0] active_delay_q, active_delay_d;
    logic [SEL_W-1:0] sel_clamped;
    logic             boundary;
    logic             delay_valid;
    stage_t           tap;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_clamped = bus.delay_sel;
        if (bus.delay_sel == '0) begin
            sel_clamped = ONE_SEL;
        end else if (bus.delay_sel > MAX_SEL) begin
            sel_clamped = MAX_SEL;
        end
    end

    assign boundary = bus.ce & bus.ctrl_in[VSYNC_BIT] & ~vsync_prev_q;

    always_comb begin
        stage_d        = stage_q;
        vsync_prev_d   = vsync_prev_q;
        fill_cnt_d     = fill_cnt_q;
        active_delay_d = active_delay_q;
        if (bus.ce) begin
            stage_d[0] = {bus.ctrl_in, bus.data_in};
            for (int k = 1; k < MAX_DELAY; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            vsync_prev_d = bus.ctrl_in[VSYNC_BIT];
            if (fill_cnt_q != MAX_SEL) begin
                fill_cnt_d = fill_cnt_q + ONE_SEL;
            end
            if (boundary) begin
                active_delay_d = sel_clamped;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            // NOTE: the stages are reset because stale payload must never reach the output tap.
            for (int k = 0; k < MAX_DELAY; k++) begin
                stage_q[k] <= '0;
            end
            vsync_prev_q   <= 1'b0;
            fill_cnt_q     <= '0;
            active_delay_q <= DEF_SEL;
        end else begin
            stage_q        <= stage_d;
            vsync_prev_q   <= vsync_prev_d;
            fill_cnt_q     <= fill_cnt_d;
            active_delay_q <= active_delay_d;
        end
    end

    // Output tap is a pure register mux, so no input reaches the outputs combinationally.
    always_comb begin
        tap = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (active_delay_q == SEL_W'(k + 1)) begin
                tap = stage_q[k];
            end
        end
    end

    assign delay_valid      = (fill_cnt_q >= active_delay_q);
    assign bus.delay_valid  = delay_valid;
    assign bus.active_delay = active_delay_q;
    assign bus.ctrl_out     = delay_valid ? tap[STAGE_W-1:DATA_WIDTH] : '0;
    assign bus.data_out     = delay_valid ? tap[DATA_WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_cmos_stream_delay.sv
// Randomized bench for cmos_stream_delay against a history-queue reference model.
module tb_cmos_stream_delay;
    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int VS   = 1;
    localparam int MAXD = 16;
    localparam int DEFD = 3;
    localparam int SW   = $clog2(MAXD + 1);
    localparam int EW   = CW + DW + 1 + SW;

    logic sck;
    logic rst;

    cmos_stream_delay_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MAX_DELAY(MAXD)) bus ();

    cmos_stream_delay #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .VSYNC_BIT(VS),
        .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
    ) dut (
        .sck (sck),
        .rst (rst),
        .bus (bus)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    // Reference model: every ce-qualified sample since reset, plus the delay in force.
    logic [CW+DW-1:0] hist[$];
    int               m_active;
    int               n_checks;
    int               n_pass;

    logic [EW-1:0] obs;
    logic [EW-1:0] exp_v;
    assign obs = {bus.ctrl_out, bus.data_out, bus.delay_valid, bus.active_delay};

    function automatic logic [EW-1:0] model_exp();
        logic [CW+DW-1:0] o;
        logic             v;
        o = '0;
        v = (hist.size() >= m_active);
        if (v) o = hist[hist.size() - m_active];
        return {o, v, SW'(m_active)};
    endfunction

    task automatic step(input logic ce_v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic [SW-1:0] sel);
        bus.ce = ce_v; bus.ctrl_in = c; bus.data_in = d; bus.delay_sel = sel;
        @(posedge sck);
        if (ce_v) begin
            logic prev;
            prev = (hist.size() == 0) ? 1'b0 : hist[hist.size()-1][DW+VS];
            if (c[VS] && !prev) begin
                if (sel == 0)               m_active = 1;
                else if (int'(sel) > MAXD)  m_active = MAXD;
                else                        m_active = int'(sel);
            end
            hist.push_back({c, d});
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        hist.delete();
        m_active = DEFD;
        @(posedge sck);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ce = 1'b0; bus.ctrl_in = '0; bus.data_in = '0; bus.delay_sel = '0;
        hist.delete();
        m_active = DEFD;
        repeat (2) @(posedge sck);
        #1;
        exp_v = {{(CW+DW){1'b0}}, 1'b0, SW'(DEFD)};
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        else n_pass++;
        #2 rst = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b00, DW'(i), SW'(3));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL fill[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (bus.delay_valid !== 1'b0 || bus.data_out !== 8'h00)
                    $display("FAIL fill_edge2: got valid=%b data=%h expected valid=0 data=00",
                             bus.delay_valid, bus.data_out);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (bus.delay_valid !== 1'b1 || bus.data_out !== 8'h00)
                    $display("FAIL fill_edge3: got valid=%b data=%h expected valid=1 data=00",
                             bus.delay_valid, bus.data_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ce_gating();
        for (int i = 0; i < 24; i++) begin
            step((i % 2) == 0, 2'b00, DW'($urandom), SW'(3));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL ce_gating[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_delay_change();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'b01, DW'($urandom), SW'(8));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL sel_ignored[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (bus.active_delay !== SW'(3))
            $display("FAIL sel_ignored_active: got %0d expected 3", bus.active_delay);
        else n_pass++;
        step(1'b1, 2'b10, DW'($urandom), SW'(8));
        n_checks++;
        if (bus.active_delay !== SW'(8))
            $display("FAIL boundary_active: got %0d expected 8", bus.active_delay);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL boundary_tap[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            step(1'b1, 2'b10, DW'($urandom), SW'(2));
        end
    endtask

    task automatic test_clamp();
        step(1'b1, 2'b00, DW'($urandom), SW'(0));
        step(1'b1, 2'b10, DW'($urandom), SW'(0));
        n_checks++;
        if (bus.active_delay !== SW'(1))
            $display("FAIL clamp_zero: got %0d expected 1", bus.active_delay);
        else n_pass++;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i == 0) ? 2'b10 : 2'b00, DW'($urandom), SW'(31));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL clamp_max[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            if (i == 14 || i == 15) begin
                n_checks++;
                if (bus.delay_valid !== (i == 15) || bus.active_delay !== SW'(16))
                    $display("FAIL clamp_max_valid[%0d]: got valid=%b active=%0d expected valid=%b active=16",
                             i, bus.delay_valid, bus.active_delay, i == 15);
                else n_pass++;
            end
        end
    endtask

    task automatic test_href_vsync_d5();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            logic [CW-1:0] c;
            c[VS] = (i % 20) < 2;
            c[0]  = ((i % 10) >= 3) && ((i % 10) <= 8);
            step(1'b1, c, DW'($urandom), SW'(5));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL align_d5[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [CW-1:0] c;
            c     = CW'($urandom);
            c[VS] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 3) != 0, c, DW'($urandom), SW'($urandom_range(0, 31)));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, 2'b01, DW'($urandom), SW'(7));
        rst = 1'b1;
        #1;
        exp_v = {{(CW+DW){1'b0}}, 1'b0, SW'(DEFD)};
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_async: got %h expected %h", obs, exp_v);
        else n_pass++;
        hist.delete();
        m_active = DEFD;
        @(posedge sck);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'b00, DW'($urandom), SW'(7));
            exp_v = model_exp();
            n_checks++;
            if (obs !== exp_v) $display("FAIL reset_refill[%0d]: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            if (i < 3) begin
                n_checks++;
                if (bus.delay_valid !== (i == 2))
                    $display("FAIL reset_refill_valid[%0d]: got %b expected %b",
                             i, bus.delay_valid, i == 2);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_fill();
        test_ce_gating();
        test_delay_change();
        test_clamp();
        test_href_vsync_d5();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
